// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: LFSR slot picker, mole dwell timer, hit/miss judge, score keeper.
// Optional MOLE_SPEEDUP_EN: dwell reload shrinks by one tick per 4 points, floored at MIN_TICKS.
module mole_game_ctrl #(
  parameter int         MOLE_TICKS  = 8,
  parameter int         FLASH_TICKS = 2,
  parameter int         MAX_MISSES  = 3,
  parameter logic [7:0] LFSR_SEED   = 8'hA5,
  parameter int         MIN_TICKS   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [2:0] btn_pos,
  output logic [2:0] mole_position,
  output logic [7:0] score,
  output logic       guess_correct,
  output logic       guess_wrong,
  output logic       game_over,
  output logic [2:0] misses
);
  localparam int DW = $clog2(MOLE_TICKS + 1);
  localparam int FW = $clog2(FLASH_TICKS + 1);

  typedef enum logic [1:0] {IDLE, SHOW, FLASH, OVER} state_t;

  state_t        state, state_nx;
  logic [7:0]    lfsr;
  logic [DW-1:0] dwell, dwell_nx, dwell_reload;
  logic [FW-1:0] flash, flash_nx;
  logic [2:0]    pos_nx, misses_nx, slot_raw, slot_new;
  logic [7:0]    score_nx;
  logic          gc_nx, gw_nx, go_nx;

  // Bump to the neighbouring slot when the draw repeats the current mole.
  assign slot_raw = 3'(lfsr % 8'd5);
  assign slot_new = (slot_raw != mole_position) ? slot_raw :
                    (slot_raw == 3'd4)          ? 3'd0     : slot_raw + 3'd1;

`ifdef MOLE_SPEEDUP_EN
  localparam int SPAN = MOLE_TICKS - MIN_TICKS;
  logic [5:0] level;
  assign level = score[7:2];
  always_comb begin
    if (int'(level) >= SPAN) dwell_reload = DW'(MIN_TICKS);
    else                     dwell_reload = DW'(MOLE_TICKS - int'(level));
  end
`else
  // MIN_TICKS never exceeds MOLE_TICKS, so this is always MOLE_TICKS.
  assign dwell_reload = DW'((MOLE_TICKS > MIN_TICKS) ? MOLE_TICKS : MIN_TICKS);
`endif

  always_comb begin
    state_nx  = state;
    pos_nx    = mole_position;
    score_nx  = score;
    misses_nx = misses;
    gc_nx     = guess_correct;
    gw_nx     = guess_wrong;
    go_nx     = game_over;
    dwell_nx  = dwell;
    flash_nx  = flash;
    case (state)
      IDLE: if (start) begin
        state_nx = SHOW;
        pos_nx   = slot_new;
        dwell_nx = dwell_reload;
      end
      SHOW: begin
        // A press wins over an expiring tick in the same cycle.
        if (btn_valid) begin
          if (btn_pos == mole_position) begin
            score_nx = (score == 8'hFF) ? score : score + 8'd1;
            gc_nx    = 1'b1;
          end else begin
            misses_nx = misses + 3'd1;
            gw_nx     = 1'b1;
          end
          state_nx = FLASH;
          flash_nx = FW'(FLASH_TICKS);
        end else if (tick) begin
          if (dwell == DW'(1)) begin
            misses_nx = misses + 3'd1;
            gw_nx     = 1'b1;
            state_nx  = FLASH;
            flash_nx  = FW'(FLASH_TICKS);
          end else begin
            dwell_nx = dwell - DW'(1);
          end
        end
      end
      FLASH: if (tick) begin
        if (flash == FW'(1)) begin
          gc_nx = 1'b0;
          gw_nx = 1'b0;
          if (misses == 3'(MAX_MISSES)) begin
            state_nx = OVER;
            go_nx    = 1'b1;
          end else begin
            state_nx = SHOW;
            pos_nx   = slot_new;
            dwell_nx = dwell_reload;
          end
        end else begin
          flash_nx = flash - FW'(1);
        end
      end
      OVER: if (start) begin
        // Score is cleared in this same edge, so reload from the zero-score dwell.
        state_nx  = SHOW;
        score_nx  = 8'd0;
        misses_nx = 3'd0;
        go_nx     = 1'b0;
        pos_nx    = slot_new;
        dwell_nx  = DW'(MOLE_TICKS);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      mole_position <= 3'd0;
      score         <= 8'd0;
      misses        <= 3'd0;
      guess_correct <= 1'b0;
      guess_wrong   <= 1'b0;
      game_over     <= 1'b0;
      dwell         <= '0;
      flash         <= '0;
    end else begin
      state         <= state_nx;
      lfsr          <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      mole_position <= pos_nx;
      score         <= score_nx;
      misses        <= misses_nx;
      guess_correct <= gc_nx;
      guess_wrong   <= gw_nx;
      game_over     <= go_nx;
      dwell         <= dwell_nx;
      flash         <= flash_nx;
    end
  end
endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: directed vector table, async reset, score saturation, random play vs model.
module tb_mole_game_ctrl;
  localparam int         MT   = 8;
  localparam int         FT   = 2;
  localparam int         MM   = 3;
  localparam int         MN   = 2;
  localparam logic [7:0] SEED = 8'hA5;
  localparam int M_IDLE = 0, M_SHOW = 1, M_FLASH = 2, M_OVER = 3;

  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0, btn_valid = 1'b0;
  logic [2:0] btn_pos = 3'd0;
  logic [2:0] mole_position, misses;
  logic [7:0] score;
  logic       guess_correct, guess_wrong, game_over;

  mole_game_ctrl #(.MOLE_TICKS(MT), .FLASH_TICKS(FT), .MAX_MISSES(MM),
                   .LFSR_SEED(SEED), .MIN_TICKS(MN)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .btn_valid(btn_valid),
    .btn_pos(btn_pos), .mole_position(mole_position), .score(score),
    .guess_correct(guess_correct), .guess_wrong(guess_wrong),
    .game_over(game_over), .misses(misses));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: game rules in plain integers.
  int m_mode, m_pos, m_score, m_miss, m_dwell, m_flash, m_lfsr;
  bit m_gc, m_gw, m_go;

  function automatic int reload(input int sc);
`ifdef MOLE_SPEEDUP_EN
    int d;
    d = MT - sc / 4;
    return (d < MN) ? MN : d;
`else
    return MT + 0 * sc;
`endif
  endfunction

  function automatic int pick(input int l, input int cur);
    int r;
    r = l % 5;
    return (r == cur) ? (r + 1) % 5 : r;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_score = 0; m_miss = 0;
    m_dwell = 0; m_flash = 0; m_lfsr = int'(SEED);
    m_gc = 0; m_gw = 0; m_go = 0;
  endtask

  task automatic miss_flash();
    m_miss++; m_gw = 1; m_mode = M_FLASH; m_flash = FT;
  endtask

  task automatic model_step(input bit t, input bit s, input bit bv, input int bp);
    int nx;
    nx = pick(m_lfsr, m_pos);
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_IDLE: if (s) begin m_mode = M_SHOW; m_pos = nx; m_dwell = reload(m_score); end
      M_SHOW: begin
        if (bv) begin
          if (bp == m_pos) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_gc = 1; m_mode = M_FLASH; m_flash = FT;
          end else miss_flash();
        end else if (t) begin
          m_dwell--;
          if (m_dwell == 0) miss_flash();
        end
      end
      M_FLASH: if (t) begin
        m_flash--;
        if (m_flash == 0) begin
          m_gc = 0; m_gw = 0;
          if (m_miss == MM) begin m_mode = M_OVER; m_go = 1; end
          else begin m_mode = M_SHOW; m_pos = nx; m_dwell = reload(m_score); end
        end
      end
      default: if (s) begin
        m_score = 0; m_miss = 0; m_go = 0;
        m_mode = M_SHOW; m_pos = nx; m_dwell = reload(0);
      end
    endcase
    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("m_pos",  8'(mole_position), 8'(m_pos));
    chk("m_score", score, 8'(m_score));
    chk("m_miss", 8'(misses), 8'(m_miss));
    chk("m_gc",   8'(guess_correct), 8'(m_gc));
    chk("m_gw",   8'(guess_wrong), 8'(m_gw));
    chk("m_go",   8'(game_over), 8'(m_go));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pos"},   8'(mole_position), 8'd0);
    chk({tag, "_score"}, score, 8'd0);
    chk({tag, "_miss"},  8'(misses), 8'd0);
    chk({tag, "_gc"},    8'(guess_correct), 8'd0);
    chk({tag, "_gw"},    8'(guess_wrong), 8'd0);
    chk({tag, "_go"},    8'(game_over), 8'd0);
  endtask

  task automatic cyc(input bit t, input bit s, input bit bv, input int bp);
    tick = t; start = s; btn_valid = bv; btn_pos = 3'(bp);
    @(posedge clk);
    model_step(t, s, bv, bp);
    @(negedge clk);
    cmp_model();
    tick = 0; start = 0; btn_valid = 0; btn_pos = 3'd0;
  endtask

  // kind: 0 no press, 1 press the mole, 2 press slot 7, 3 press the neighbouring slot
  typedef struct {
    bit t, s, bv;
    int kind;
    int sc, ms;
    bit gc, gw, go;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit t, input bit s, input bit bv, input int kind,
                     input int sc, input int ms, input bit gc, input bit gw, input bit go);
    vec_t v;
    v.t = t; v.s = s; v.bv = bv; v.kind = kind;
    v.sc = sc; v.ms = ms; v.gc = gc; v.gw = gw; v.go = go;
    tbl.push_back(v);
  endtask

  initial begin
    int bp, n;
    bit done, sat_hit;
    add(0,1,0,0, 0,0,0,0,0);                           // start
    add(1,0,0,0, 0,0,0,0,0);
    add(0,0,1,1, 1,0,1,0,0);                           // hit
    add(1,0,0,0, 1,0,1,0,0);
    add(0,0,1,3, 1,0,1,0,0);                           // press during flash ignored
    add(1,0,0,0, 1,0,0,0,0);                           // flash ends after FT ticks
    add(0,0,1,2, 1,1,0,1,0);                           // slot 7 is a miss
    add(1,0,0,0, 1,1,0,1,0);
    add(1,0,0,0, 1,1,0,0,0);
    add(0,0,1,3, 1,2,0,1,0);                           // wrong valid slot
    add(0,1,0,0, 1,2,0,1,0);                           // start ignored in flash
    add(1,0,0,0, 1,2,0,1,0);
    add(1,0,0,0, 1,2,0,0,0);
    for (int i = 0; i < MT - 1; i++) add(1,0,0,0, 1,2,0,0,0);
    add(1,0,1,1, 2,2,1,0,0);                           // hit on the expiring tick
    add(1,0,0,0, 2,2,1,0,0);
    add(1,0,0,0, 2,2,0,0,0);
    for (int i = 0; i < MT - 1; i++) add(1,0,0,0, 2,2,0,0,0);
    add(1,0,0,0, 2,3,0,1,0);                           // timeout
    add(1,0,0,0, 2,3,0,1,0);
    add(1,0,0,0, 2,3,0,0,1);                           // game over
    add(1,0,0,0, 2,3,0,0,1);
    add(0,0,1,1, 2,3,0,0,1);
    add(0,1,0,0, 0,0,0,0,0);                           // restart clears score/misses
    add(0,0,1,1, 1,0,1,0,0);                           // leave it mid-flash

    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        1: bp = m_pos;
        2: bp = 7;
        3: bp = (m_pos + 1) % 5;
        default: bp = 0;
      endcase
      cyc(tbl[i].t, tbl[i].s, tbl[i].bv, bp);
      chk($sformatf("tbl%0d_score", i), score, 8'(tbl[i].sc));
      chk($sformatf("tbl%0d_miss", i), 8'(misses), 8'(tbl[i].ms));
      chk($sformatf("tbl%0d_gc", i), 8'(guess_correct), 8'(tbl[i].gc));
      chk($sformatf("tbl%0d_gw", i), 8'(guess_wrong), 8'(tbl[i].gw));
      chk($sformatf("tbl%0d_go", i), 8'(game_over), 8'(tbl[i].go));
    end

    // Asynchronous reset in the middle of a flash, sampled before any clock edge.
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    model_reset();
    cyc(0,0,0,0);
    cyc(0,0,0,0);
    rst_n = 1'b1;
    cyc(0,1,0,0);

    for (int i = 0; i < 2000; i++) begin
      bp = ($urandom_range(0, 1) == 1) ? m_pos : int'($urandom_range(0, 7));
      cyc(bit'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, bp);
    end

    // Drive the score to saturation, then score once more.
    rst_n = 1'b0;
    cyc(0,0,0,0);
    rst_n = 1'b1;
    cyc(0,1,0,0);
    done = 0;
    n = 0;
    while (!done && n < 3000) begin
      n++;
      if (m_mode == M_SHOW) begin
        sat_hit = (m_score == 255);
        cyc(0,0,1,m_pos);
        if (sat_hit) begin
          done = 1;
          chk("sat_score", score, 8'd255);
          chk("sat_gc", 8'(guess_correct), 8'd1);
        end
      end else cyc(1,0,0,0);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL sat_timeout got %0d want 255", score);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
